// File: rtl/stage4_net_interface.sv
// Stage-4 network interface: TX FIFO for outbound stores, RX FIFO for inbound
// loads, plus the combinational stall/handshake layer between them and the pipeline.

module stage4_net_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty,
  output logic                    full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW + 1)'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // NOTE: storage is deliberately left out of reset; the pointers and count
  // define which entries are valid, so clearing the array buys nothing.
  always_ff @(posedge clk) begin
    if (do_push && !rst) mem[wr_ptr] <= din;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Pointers are log2(DEPTH) bits wide, so the increment wraps modulo DEPTH.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module stage4_net_interface #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    NET_INTER_WRITE,
  input  logic                    NET_INTER_READ,
  input  logic [DATA_WIDTH-1:0]   WRITE_DATA,
  input  logic [DEST_WIDTH-1:0]   DEST_ADDR,
  output logic [DATA_WIDTH-1:0]   READ_DATA,
  output logic                    BUSYWAIT,
  output logic                    TX_VALID,
  input  logic                    TX_READY,
  output logic [DATA_WIDTH-1:0]   TX_DATA,
  output logic [DEST_WIDTH-1:0]   TX_DEST,
  input  logic                    RX_VALID,
  output logic                    RX_READY,
  input  logic [DATA_WIDTH-1:0]   RX_DATA,
  output logic [$clog2(DEPTH):0]  TX_COUNT,
  output logic [$clog2(DEPTH):0]  RX_COUNT
);
  localparam int TXW = DEST_WIDTH + DATA_WIDTH;

  logic           wr_req;
  logic           rd_req;
  logic           tx_empty;
  logic           tx_full;
  logic           rx_empty;
  logic           rx_full;
  logic           tx_push;
  logic           tx_pop;
  logic           rx_push;
  logic           rx_pop;
  logic [TXW-1:0] tx_head;
  logic [DATA_WIDTH-1:0] rx_head;

  // A store wins over a same-cycle load; the load is simply not seen that cycle.
  assign wr_req = NET_INTER_WRITE;
  assign rd_req = NET_INTER_READ & ~NET_INTER_WRITE;

  assign BUSYWAIT = ~RESET & ((wr_req & tx_full) | (rd_req & rx_empty));

  assign tx_push = wr_req & ~tx_full;
  assign tx_pop  = ~tx_empty & TX_READY;
  assign rx_pop  = rd_req & ~rx_empty;

  // RX_READY ignores a same-cycle pop, so a full RX FIFO never passes data through.
  assign RX_READY = ~RESET & ~rx_full;
  assign rx_push  = RX_VALID & RX_READY;

  assign TX_VALID  = ~tx_empty;
  assign TX_DATA   = tx_head[DATA_WIDTH-1:0];
  assign TX_DEST   = tx_head[TXW-1:DATA_WIDTH];
  assign READ_DATA = rx_empty ? '0 : rx_head;

  stage4_net_fifo #(.DEPTH(DEPTH), .WIDTH(TXW)) u_tx_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   ({DEST_ADDR, WRITE_DATA}),
    .head  (tx_head),
    .count (TX_COUNT),
    .empty (tx_empty),
    .full  (tx_full)
  );

  stage4_net_fifo #(.DEPTH(DEPTH), .WIDTH(DATA_WIDTH)) u_rx_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (RX_DATA),
    .head  (rx_head),
    .count (RX_COUNT),
    .empty (rx_empty),
    .full  (rx_full)
  );
endmodule
